base64_regfile_loader: RTL and testbench
========================================

Name: base64_regfile_loader

Overview:
- Write-side front end for the 8-entry x 6-bit sextet register file.
- Accepts a binary byte stream through a valid/ready handshake.
- Repacks every 3 bytes into 4 Base64 sextets (MSB first) and drives WA2..WA0/WR/LD_DATA to store sextets at ascending addresses.
- Zero-pads a partial final group and reports completion, so the register file's read ports can then fetch the encoded sextets.

Parameters:
- DEPTH, 8, number of register-file entries to fill. Must be a multiple of 4 and no greater than 8.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- CLRN  input  1  asynchronous active-low clear.
- START  input  1  one-cycle pulse in IDLE; begins a new load at address 0.
- IN_DATA  input  8  byte to encode.
- IN_VALID  input  1  IN_DATA valid.
- IN_LAST  input  1  qualifies the accepted byte as the final byte.
- IN_READY  output  1  loader can accept a byte this cycle.
- WA2, WA1, WA0  output  1 each  register-file write address, MSB first.
- WR  output  1  register-file write enable.
- LD_DATA  output  6  sextet to write.
- COUNT  output  4  sextets written since START.
- FULL  output  1  COUNT == DEPTH.
- BUSY  output  1  high from START until DONE.
- DONE  output  1  one-cycle pulse after the final write.

Behaviour:
- Reset (CLRN=0, asynchronous):
  - State IDLE; all outputs 0; internal address, leftover-bit holder and phase cleared.
  - Takes effect mid-operation; any pending write is dropped.
- IDLE: IN_READY=0. START=1 → COUNT=0, address=0, BUSY=1, phase P0. START is ignored while BUSY.
- Byte transfer occurs on a rising edge with IN_VALID & IN_READY.
  - IN_READY = BUSY & ~FULL & phase ∈ {P0, P1, P2}.
- WR, WA and LD_DATA are registered. A sextet produced by a transfer at edge k is presented during cycle k+1, and the register file captures it at edge k+1.
  - Address increments and COUNT increments once per WR cycle.
- Phase behaviour:
  - P0, byte b0: write b0[7:2]; hold b0[1:0]; go to P1.
  - P1, byte b1: write {hold[1:0], b1[7:4]}; hold b1[3:0]; go to P2.
  - P2, byte b2: write {hold[3:0], b2[7:6]}; go to P3 holding b2[5:0].
  - P3: IN_READY=0; write the held b2[5:0] the next cycle; return to P0.
- IN_LAST on an accepted byte:
  - In P0 or P1: after the normal write, enter FLUSH and write the leftover bits left-justified and zero-filled. P0 gives {b0[1:0],0000}; P1 gives {b1[3:0],00}.
  - In P2: the normal P3 write is last.
  - After the final write, go to FIN: DONE=1 for one cycle, BUSY=0, then IDLE. COUNT and FULL hold until the next START.
- Full:
  - DEPTH is a multiple of 4, so FULL rises only at a group boundary (P0) and a split or flush write never exceeds capacity.
  - When FULL=1 without LAST, IN_READY stays 0 and BUSY stays 1 until reset or a subsequent LAST-free abort via CLRN. No DONE.
  - IN_LAST on the byte completing the last group: DONE follows normally.
- WR is never high on two different addresses in one cycle. No bubble is inserted between consecutive writes except P3 and FLUSH stalls of IN_READY.
- COUNT saturates at DEPTH.

Optional Feature:
- Macro: BASE64_WRAP_EN.
- Defined:
  - Address wraps from DEPTH-1 to 0 and loading continues.
  - FULL never asserts and IN_READY ignores capacity.
  - COUNT saturates at DEPTH.
  - Older sextets are overwritten in order.
- Undefined: the stop-at-full behaviour above.

Test Plan:
- START; bytes 0x4D,0x61,0x6E with LAST on 0x6E → WR at addr 0..3 with LD_DATA 19,22,5,46; COUNT=4; DONE one cycle after the addr-3 write; IN_READY=0 during the P3 cycle.
- START; 0x4D,0x61 with LAST → writes 19,22,4 at addr 0..2; COUNT=3; DONE.
- START; 0x4D with LAST → writes 19,16 at addr 0,1; COUNT=2; DONE.
- START; six bytes 0x4D,0x61,0x6E repeated, no LAST → addr 0..7 written; FULL=1; IN_READY=0 while IN_VALID is held. With BASE64_WRAP_EN: a 7th byte 0xFF writes 63 at addr 0, and FULL stays 0.
- Pull CLRN low during the P3 stall of the first group → WR=0, COUNT=0, BUSY=0 immediately. After CLRN release, START restarts at addr 0.
- Hold IN_VALID low for 3 cycles between bytes, and pulse START while BUSY → no WR during the gaps, START is ignored, and sextet values match the uninterrupted case.

Source files
------------

// File: rtl/base64_regfile_loader.sv
// Base64 write-side loader: packs a byte stream into 6-bit sextets and writes them
// to an 8x6 register file. Define BASE64_WRAP_EN to wrap the address instead of stopping at FULL.
module base64_regfile_loader #(
    parameter int DEPTH = 8
) (
    input  logic       CLK,
    input  logic       CLRN,
    input  logic       START,
    input  logic [7:0] IN_DATA,
    input  logic       IN_VALID,
    input  logic       IN_LAST,
    output logic       IN_READY,
    output logic       WA2,
    output logic       WA1,
    output logic       WA0,
    output logic       WR,
    output logic [5:0] LD_DATA,
    output logic [3:0] COUNT,
    output logic       FULL,
    output logic       BUSY,
    output logic       DONE
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_P0,
        S_P1,
        S_P2,
        S_P3,
        S_FLUSH,
        S_FIN
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] addr_q, addr_d;
    logic [3:0] count_q, count_d;
    logic [5:0] hold_q, hold_d;
    logic       last_q, last_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       wr_q, wr_d;
    logic [2:0] wa_q, wa_d;
    logic [5:0] ld_q, ld_d;

    logic       full;
    logic       in_ready;
    logic       xfer;
    logic       emit;
    logic [5:0] sextet;
    logic [2:0] addr_next;
    logic [3:0] count_next;

`ifdef BASE64_WRAP_EN
    assign full      = 1'b0;
    assign addr_next = (addr_q == 3'(DEPTH - 1)) ? '0 : addr_q + 3'd1;
`else
    assign full      = (count_q == 4'(DEPTH));
    assign addr_next = addr_q + 3'd1;
`endif

    assign count_next = (count_q == 4'(DEPTH)) ? count_q : count_q + 4'd1;
    assign in_ready   = busy_q & ~full &
                        ((state_q == S_P0) | (state_q == S_P1) | (state_q == S_P2));
    assign xfer       = IN_VALID & in_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        hold_d  = hold_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        wr_d    = 1'b0;
        wa_d    = wa_q;
        ld_d    = ld_q;
        emit    = 1'b0;
        sextet  = '0;

        // hold_q keeps leftover bits left-justified so flush/P3 writes it unchanged
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d = S_P0;
                    busy_d  = 1'b1;
                    count_d = '0;
                    addr_d  = '0;
                    last_d  = 1'b0;
                end
            end
            S_P0: begin
                if (xfer) begin
                    emit    = 1'b1;
                    sextet  = IN_DATA[7:2];
                    hold_d  = {IN_DATA[1:0], 4'b0000};
                    state_d = IN_LAST ? S_FLUSH : S_P1;
                end
            end
            S_P1: begin
                if (xfer) begin
                    emit    = 1'b1;
                    sextet  = {hold_q[5:4], IN_DATA[7:4]};
                    hold_d  = {IN_DATA[3:0], 2'b00};
                    state_d = IN_LAST ? S_FLUSH : S_P2;
                end
            end
            S_P2: begin
                if (xfer) begin
                    emit    = 1'b1;
                    sextet  = {hold_q[5:2], IN_DATA[7:6]};
                    hold_d  = IN_DATA[5:0];
                    last_d  = IN_LAST;
                    state_d = S_P3;
                end
            end
            S_P3: begin
                emit    = 1'b1;
                sextet  = hold_q;
                state_d = last_q ? S_FIN : S_P0;
            end
            S_FLUSH: begin
                emit    = 1'b1;
                sextet  = hold_q;
                state_d = S_FIN;
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (emit) begin
            wr_d    = 1'b1;
            wa_d    = addr_q;
            ld_d    = sextet;
            addr_d  = addr_next;
            count_d = count_next;
        end
    end

    always_ff @(posedge CLK or negedge CLRN) begin
        if (!CLRN) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            count_q <= '0;
            hold_q  <= '0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wr_q    <= 1'b0;
            wa_q    <= '0;
            ld_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wr_q    <= wr_d;
            wa_q    <= wa_d;
            ld_q    <= ld_d;
        end
    end

    assign IN_READY = in_ready;
    assign WA2      = wa_q[2];
    assign WA1      = wa_q[1];
    assign WA0      = wa_q[0];
    assign WR       = wr_q;
    assign LD_DATA  = ld_q;
    assign COUNT    = count_q;
    assign FULL     = full;
    assign BUSY     = busy_q;
    assign DONE     = done_q;

endmodule

// File: tb/tb_base64_regfile_loader.sv
// Scoreboard bench for base64_regfile_loader: expected writes are queued by the
// stimulus and popped by a monitor on every WR cycle.
module tb_base64_regfile_loader;

    logic       CLK = 1'b0;
    logic       CLRN = 1'b0;
    logic       START = 1'b0;
    logic [7:0] IN_DATA = '0;
    logic       IN_VALID = 1'b0;
    logic       IN_LAST = 1'b0;
    logic       IN_READY, WA2, WA1, WA0, WR, FULL, BUSY, DONE;
    logic [5:0] LD_DATA;
    logic [3:0] COUNT;

    base64_regfile_loader #(.DEPTH(8)) dut (
        .CLK(CLK), .CLRN(CLRN), .START(START),
        .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_LAST(IN_LAST),
        .IN_READY(IN_READY), .WA2(WA2), .WA1(WA1), .WA0(WA0),
        .WR(WR), .LD_DATA(LD_DATA), .COUNT(COUNT), .FULL(FULL),
        .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct { int addr; int data; } wr_t;
    wr_t exp_q[$];

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int last_wr_cyc = -10;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic expect_wr(input int addr, input int data);
        wr_t w;
        w.addr = addr;
        w.data = data;
        exp_q.push_back(w);
    endtask

    // Monitor: every WR cycle must match the head of the expected queue.
    always @(negedge CLK) begin
        if (WR) begin
            last_wr_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_wr", {WA2, WA1, WA0}, -1);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("wr_addr", {WA2, WA1, WA0}, w.addr);
                check("wr_data", LD_DATA, w.data);
            end
        end
    end

    task automatic pulse_start();
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    // Presents a byte from a negedge and returns right after the accepting posedge.
    task automatic send(input logic [7:0] b, input logic last);
        bit ok = 0;
        @(negedge CLK);
        IN_DATA  = b;
        IN_LAST  = last;
        IN_VALID = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (IN_READY) begin
                @(posedge CLK);
                ok = 1;
                break;
            end
            @(negedge CLK);
        end
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic idle_inputs();
        @(negedge CLK);
        IN_VALID = 1'b0;
        IN_LAST  = 1'b0;
    endtask

    task automatic wait_done(input int exp_count);
        bit seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (DONE) begin
                seen = 1;
                break;
            end
        end
        check("done_seen", seen, 1);
        if (seen) begin
            check("done_after_last_wr", cyc - last_wr_cyc, 1);
            check("count_at_done", COUNT, exp_count);
            check("busy_at_done", BUSY, 0);
            @(negedge CLK);
            check("done_one_cycle", DONE, 0);
        end
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        #1 CLRN = 1'b0;
        IN_VALID = 1'b0;
        IN_LAST  = 1'b0;
        #1;
        check("rst_wr", WR, 0);
        check("rst_count", COUNT, 0);
        check("rst_busy", BUSY, 0);
        check("rst_ready", IN_READY, 0);
        check("rst_done", DONE, 0);
        exp_q.delete();
        @(negedge CLK);
        CLRN = 1'b1;
    endtask

    initial begin
        // reset state
        #2;
        check("rst0_wr", WR, 0);
        check("rst0_busy", BUSY, 0);
        check("rst0_full", FULL, 0);
        @(negedge CLK);
        CLRN = 1'b1;
        @(negedge CLK);
        check("idle_ready", IN_READY, 0);

        // "Man" -> TWFu
        pulse_start();
        check("busy_after_start", BUSY, 1);
        check("count_after_start", COUNT, 0);
        expect_wr(0, 19); expect_wr(1, 22); expect_wr(2, 5); expect_wr(3, 46);
        send(8'h4D, 1'b0);
        send(8'h61, 1'b0);
        send(8'h6E, 1'b1);
        @(negedge CLK);
        check("ready_in_p3", IN_READY, 0);
        IN_VALID = 1'b0;
        IN_LAST  = 1'b0;
        wait_done(4);

        // "Ma" -> two full sextets plus a flushed one
        pulse_start();
        expect_wr(0, 19); expect_wr(1, 22); expect_wr(2, 4);
        send(8'h4D, 1'b0);
        send(8'h61, 1'b1);
        idle_inputs();
        wait_done(3);

        // "M" -> one sextet plus a flushed one
        pulse_start();
        expect_wr(0, 19); expect_wr(1, 16);
        send(8'h4D, 1'b1);
        idle_inputs();
        wait_done(2);

        // Fill to capacity without LAST
        pulse_start();
        for (int g = 0; g < 2; g++) begin
            expect_wr(g * 4 + 0, 19); expect_wr(g * 4 + 1, 22);
            expect_wr(g * 4 + 2, 5);  expect_wr(g * 4 + 3, 46);
            send(8'h4D, 1'b0);
            send(8'h61, 1'b0);
            send(8'h6E, 1'b0);
        end
        idle_inputs();
        repeat (3) @(negedge CLK);
        check("count_full", COUNT, 8);
        check("busy_full", BUSY, 1);
        check("queue_full_drained", exp_q.size(), 0);
`ifdef BASE64_WRAP_EN
        check("full_wrap", FULL, 0);
        expect_wr(0, 63);
        send(8'hFF, 1'b0);
        idle_inputs();
        repeat (2) @(negedge CLK);
        check("full_wrap_after", FULL, 0);
        check("count_sat", COUNT, 8);
        check("queue_wrap_drained", exp_q.size(), 0);
`else
        check("full_flag", FULL, 1);
        IN_DATA  = 8'hFF;
        IN_VALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("ready_when_full", IN_READY, 0);
        end
        IN_VALID = 1'b0;
        check("done_absent_full", DONE, 0);
`endif
        do_reset();

        // Reset during the P3 stall drops the pending write
        pulse_start();
        expect_wr(0, 19); expect_wr(1, 22); expect_wr(2, 5);
        send(8'h4D, 1'b0);
        send(8'h61, 1'b0);
        send(8'h6E, 1'b0);
        do_reset();
        pulse_start();
        expect_wr(0, 19); expect_wr(1, 16);
        send(8'h4D, 1'b1);
        idle_inputs();
        wait_done(2);

        // Gaps between bytes and an ignored START while busy
        pulse_start();
        expect_wr(0, 19); expect_wr(1, 22); expect_wr(2, 5); expect_wr(3, 46);
        send(8'h4D, 1'b0);
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (i == 0) START = 1'b1;
            else START = 1'b0;
            if (i > 0) check("no_wr_in_gap", WR, 0);
        end
        check("count_after_ignored_start", COUNT, 1);
        check("busy_after_ignored_start", BUSY, 1);
        send(8'h61, 1'b0);
        idle_inputs();
        repeat (2) @(negedge CLK);
        check("no_wr_in_gap2", WR, 0);
        send(8'h6E, 1'b1);
        idle_inputs();
        wait_done(4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1);
    end

endmodule
